// File: rtl/add64_sequencer.sv
// add64_sequencer: drives a 32-bit combinational adder word by word to build a WORDS*32-bit add/subtract
module add64_sequencer #(
    parameter int WORDS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  sub,
    input  logic [32*WORDS-1:0]   op_a,
    input  logic [32*WORDS-1:0]   op_b,
    output logic [31:0]           add_a,
    output logic [31:0]           add_b,
    output logic                  add_cin,
    input  logic [31:0]           add_sum,
    input  logic                  add_cout,
    input  logic                  add_ovf,
    output logic [32*WORDS-1:0]   result,
    output logic                  carry,
    output logic                  overflow,
    output logic                  zero,
    output logic                  busy,
    output logic                  done
);
    localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t                  state, state_nx;
    logic [IW-1:0]           idx;
    logic [WORDS-1:0][31:0]  a_q, b_q, work, work_nx;
    logic                    sub_q, cy, accept, last;
    assign last = idx == IW'(WORDS - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                accept   = start;
                state_nx = start ? RUN : IDLE;
            end
            RUN: begin
                busy     = 1'b1;
                state_nx = last ? DONE : RUN;
            end
            DONE: begin
                done     = 1'b1;
                accept   = start;
                state_nx = start ? RUN : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
    // word 0 takes the add/sub carry-in, later words chain the previous carry-out
    always_comb begin
        add_a        = busy ? a_q[idx] : 32'd0;
        add_b        = busy ? (sub_q ? ~b_q[idx] : b_q[idx]) : 32'd0;
        add_cin      = busy & (idx == '0 ? sub_q : cy);
        work_nx      = work;
        work_nx[idx] = add_sum;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            work     <= '0;
            cy       <= 1'b0;
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (accept) begin
            a_q   <= op_a;
            b_q   <= op_b;
            sub_q <= sub;
            idx   <= '0;
        end else if (busy) begin
            work <= work_nx;
            cy   <= add_cout;
            if (last) begin
                result   <= work_nx;
                carry    <= add_cout;
                overflow <= add_ovf;
                zero     <= ~|work_nx;
                idx      <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_add64_sequencer.sv
// tb_add64_sequencer: randomized and directed checks of add64_sequencer against an arithmetic reference
module tb_add64_sequencer;
    localparam int WORDS = 2;
    localparam int W = 32 * WORDS;
    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, sub = 1'b0;
    logic [W-1:0]  op_a = '0, op_b = '0, result;
    logic [31:0]   add_a, add_b, add_sum;
    logic          add_cin, add_cout, add_ovf, carry, overflow, zero, busy, done;
    int checks = 0, failures = 0;

    typedef struct packed {
        logic [63:0] a, b;
        logic        s;
        logic [63:0] r;
        logic        c, v, z, c1;
    } vec_t;
    vec_t dir [5] = '{
        '{64'h00000000_FFFFFFFF, 64'h1, 1'b0, 64'h00000001_00000000, 1'b0, 1'b0, 1'b0, 1'b1},
        '{64'h7FFFFFFF_FFFFFFFF, 64'h1, 1'b0, 64'h80000000_00000000, 1'b0, 1'b1, 1'b0, 1'b1},
        '{64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 64'hFFFFFFFF_FFFFFFFE, 1'b1, 1'b0, 1'b0, 1'b1},
        '{64'h5, 64'h5, 1'b1, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1},
        '{64'h0, 64'h1, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0}
    };

    add64_sequencer #(.WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .op_a(op_a), .op_b(op_b),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum),
        .add_cout(add_cout), .add_ovf(add_ovf), .result(result), .carry(carry),
        .overflow(overflow), .zero(zero), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always_comb begin
        {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + 33'(add_cin);
        add_ovf = (add_a[31] == add_b[31]) && (add_sum[31] != add_a[31]);
    end

    // returns {overflow, zero, carry, result} from plain wide arithmetic
    function automatic logic [66:0] model(input logic [63:0] a, input logic [63:0] b, input logic s);
        logic [63:0] r;
        logic [64:0] wide;
        logic signed [65:0] sx;
        logic c;
        r    = s ? a - b : a + b;
        wide = {1'b0, a} + {1'b0, b};
        c    = s ? (a >= b) : wide[64];
        sx   = s ? $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b})
                 : $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
        return {(sx > 66'sh7FFFFFFF_FFFFFFFF) || (sx < -66'sh80000000_00000000), r == 64'd0, c, r};
    endfunction

    task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                         output int lat, output int busy_n, output int done_n,
                         output logic cin0, output logic cin1);
        lat = -1; busy_n = 0; done_n = 0; cin0 = 1'b0; cin1 = 1'b0;
        @(negedge clk);
        op_a = a; op_b = b; sub = s; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a = {$urandom, $urandom};
        op_b = {$urandom, $urandom};
        sub = ~s;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (busy) begin
                if (busy_n == 0) cin0 = add_cin;
                else cin1 = add_cin;
                busy_n++;
            end
            if (done) begin
                done_n++;
                if (lat < 0) lat = i;
            end
        end
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({busy, done, carry, overflow, zero, add_cin} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000000", {busy, done, carry, overflow, zero, add_cin});
        end
        checks++;
        if (result !== '0 || add_a !== '0 || add_b !== '0) begin
            failures++;
            $display("FAIL reset_data result=%h add_a=%h add_b=%h exp all zero", result, add_a, add_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        int lat, bn, dn;
        logic c0, c1;
        for (int k = 0; k < 5; k++) begin
            do_op(dir[k].a, dir[k].b, dir[k].s, lat, bn, dn, c0, c1);
            checks++;
            if (result !== dir[k].r) begin
                failures++;
                $display("FAIL dir%0d_result got=%h exp=%h", k, result, dir[k].r);
            end
            checks++;
            if ({carry, overflow, zero} !== {dir[k].c, dir[k].v, dir[k].z}) begin
                failures++;
                $display("FAIL dir%0d_flags cvz got=%b exp=%b", k, {carry, overflow, zero}, {dir[k].c, dir[k].v, dir[k].z});
            end
            checks++;
            if ({c0, c1} !== {dir[k].s, dir[k].c1}) begin
                failures++;
                $display("FAIL dir%0d_cin got=%b exp=%b", k, {c0, c1}, {dir[k].s, dir[k].c1});
            end
            checks++;
            if (lat != WORDS + 1 || bn != WORDS || dn != 1) begin
                failures++;
                $display("FAIL dir%0d_timing lat=%0d busy=%0d done=%0d exp %0d/%0d/1", k, lat, bn, dn, WORDS + 1, WORDS);
            end
        end
    endtask

    task automatic test_random;
        int lat, bn, dn;
        logic c0, c1;
        logic [63:0] a, b;
        logic s;
        logic [66:0] e;
        for (int k = 0; k < 40; k++) begin
            a = {$urandom, $urandom};
            b = (k % 5 == 0) ? a : {$urandom, $urandom};
            if (k % 7 == 3) a[31:0] = 32'hFFFFFFFF;
            s = 1'($urandom_range(0, 1));
            e = model(a, b, s);
            do_op(a, b, s, lat, bn, dn, c0, c1);
            checks++;
            if ({overflow, zero, carry, result} !== e || lat != WORDS + 1 || dn != 1 || c0 !== s) begin
                failures++;
                $display("FAIL rand%0d a=%h b=%h s=%b got v/z/c/r=%b%b%b/%h exp=%b%b%b/%h lat=%0d done=%0d cin0=%b",
                         k, a, b, s, overflow, zero, carry, result, e[66], e[65], e[64], e[63:0], lat, dn, c0);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] va [6];
        logic [63:0] b;
        b = {$urandom, $urandom};
        for (int k = 0; k < 6; k++) va[k] = {$urandom, $urandom};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 3) begin
                checks++;
                if (done !== 1'b1 || result !== va[0] + b) begin
                    failures++;
                    $display("FAIL b2b_first done=%b result=%h exp done=1 result=%h", done, result, va[0] + b);
                end
            end
            if (k == 4) begin
                checks++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_restart busy=%b done=%b exp busy=1 done=0", busy, done);
                end
            end
            op_a = va[k]; op_b = b; sub = 1'b0; start = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || result !== va[3] + b) begin
            failures++;
            $display("FAIL b2b_second done=%b result=%h exp done=1 result=%h", done, result, va[3] + b);
        end
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle busy=%b done=%b exp 0/0", busy, done);
        end
    endtask

    task automatic test_start_during_run;
        logic [63:0] a, b;
        int dn, bn;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        @(negedge clk);
        op_a = a; op_b = b; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        op_a = ~a; sub = 1'b0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL run_ignore_mid busy=%b done=%b exp busy=1 done=0", busy, done);
        end
        dn = 0; bn = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            dn += int'(done);
            bn += int'(busy);
        end
        checks++;
        if (dn != 1 || bn != 0 || result !== a - b) begin
            failures++;
            $display("FAIL run_ignore done=%0d busy=%0d result=%h exp done=1 busy=0 result=%h", dn, bn, result, a - b);
        end
    endtask

    task automatic test_reset_mid_run;
        int lat, bn, dn;
        logic c0, c1;
        logic [63:0] a, b;
        do_op(64'h1, 64'h2, 1'b0, lat, bn, dn, c0, c1);
        @(negedge clk);
        op_a = 64'h12345678_9ABCDEF0; op_b = 64'h0FEDCBA9_87654321; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || result !== 64'h3) begin
            failures++;
            $display("FAIL rst_pre busy=%b result=%h exp busy=1 result=3", busy, result);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || add_a !== '0 || add_b !== '0) begin
            failures++;
            $display("FAIL rst_mid busy=%b done=%b result=%h add_a=%h add_b=%h exp all zero", busy, done, result, add_a, add_b);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        do_op(a, b, 1'b1, lat, bn, dn, c0, c1);
        checks++;
        if (result !== a - b || carry !== (a >= b) || lat != WORDS + 1 || dn != 1) begin
            failures++;
            $display("FAIL rst_after result=%h carry=%b lat=%0d exp result=%h carry=%b lat=%0d", result, carry, lat, a - b, a >= b, WORDS + 1);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_back_to_back;
        test_start_during_run;
        test_reset_mid_run;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/add64_sequencer.md
Name: add64_sequencer

Overview:
Multi-cycle wide-add controller that sits directly upstream of the 32-bit adder and feeds it. It splits WORDS*32-bit operands into 32-bit words, drives the adder one word per cycle (least significant word first), and chains the adder's carry-out back into its carry-in. It collects the sums and flags into a registered wide result. Add and subtract are supported; subtract uses invert-B plus carry-in = 1.

Parameters:
WORDS, 2, number of 32-bit words per operand (>=1); operand/result width W = 32*WORDS

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous reset, active-low
start  input  1  request; sampled only in IDLE or DONE
sub  input  1  0 = A+B, 1 = A-B; latched with operands
op_a  input  W  operand A; latched on accepted start
op_b  input  W  operand B; latched on accepted start
add_a  output  32  to adder input a
add_b  output  32  to adder input b
add_cin  output  1  to adder cy_in
add_sum  input  32  from adder sum
add_cout  input  1  from adder carryflag
add_ovf  input  1  from adder overflowflag
result  output  W  final sum/difference; registered
carry  output  1  final carry-out; for sub, 1 = no borrow
overflow  output  1  signed overflow, taken from the most significant word only
zero  output  1  result == 0
busy  output  1  high while in RUN
done  output  1  one-cycle pulse on completion

Behaviour:
- States: IDLE, RUN, DONE. Word index idx runs 0..WORDS-1 and is held in a register.
- Reset (async, rst_n=0): state=IDLE, idx=0, internal operand/working registers=0, result=0, carry=0, overflow=0, zero=0, busy=0, done=0. Reset during RUN abandons the operation; no partial result becomes visible.
- IDLE: busy=0, done=0. start=1 at an edge: latch op_a, op_b, sub; idx<=0; go to RUN.
- RUN (busy=1): combinational adder drive:
  - add_a = A word[idx]
  - add_b = B word[idx], bitwise inverted when sub=1
  - add_cin = sub when idx==0, otherwise the registered carry from the previous word
- Each RUN edge: working word[idx] <= add_sum; carry register <= add_cout.
  - If idx==WORDS-1: result <= full working value including this word; carry <= add_cout; overflow <= add_ovf; zero <= (full value == 0); go to DONE.
  - Otherwise: idx <= idx+1.
- Outside RUN: add_a=0, add_b=0, add_cin=0.
- DONE: done=1 for exactly one cycle, busy=0.
  - start=1 here is accepted as in IDLE (back-to-back); go to RUN.
  - Otherwise go to IDLE.
- Latency: start sampled at edge 0 gives done high in the cycle after edge WORDS. Throughput is one op per WORDS+1 cycles.
- start during RUN is ignored and is not queued. op_a, op_b and sub may change freely after acceptance.
- result, carry, overflow and zero update only on entry to DONE. They hold their values through IDLE and the next RUN until the next completion.
- The adder is treated as purely combinational. Its outputs are sampled at the same edge as the inputs driven that cycle.
- WORDS=1: a single RUN cycle; add_cin = sub.

Test Plan:
- A=0x00000000_FFFFFFFF, B=0x00000000_00000001, sub=0 -> add_cin=0 in word0, 1 in word1; result=0x00000001_00000000; carry=0, overflow=0, zero=0; busy high 2 cycles; done pulses exactly once, 2 edges after start.
- A=0x7FFFFFFF_FFFFFFFF, B=1, sub=0 -> result=0x80000000_00000000, overflow=1, carry=0.
- A=B=0xFFFFFFFF_FFFFFFFF, sub=0 -> result=0xFFFFFFFF_FFFFFFFE, carry=1, overflow=0.
- sub=1, A=5, B=5 -> result=0, zero=1, carry=1, overflow=0. Then sub=1, A=0, B=1 -> result=0xFFFFFFFF_FFFFFFFF, carry=0.
- start held high for 6 cycles with changing op_a -> first op completes using the latched value; start in DONE cycle begins a second op with no IDLE cycle; start pulses during RUN have no effect.
- rst_n pulled low mid-RUN (idx=1) -> immediately busy=0, done=0, result=0, add_a=add_b=0. After release, the next start completes normally with correct values.
